// File: rtl/muskbus_line_reader_pkg.sv
// Shared Muskbus definitions: bus tags, line reader state encoding and address helper.
package MUSKBUS;

  localparam int unsigned WORD_BITS = 64;
  localparam int unsigned TAG_BITS  = 8;

  localparam logic [TAG_BITS-1:0] READ_MEM_TAG = 8'h02;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } LINE_READER_STATE_T;

  // Clear the low ofs_bits byte-offset bits of an address.
  function automatic logic [WORD_BITS-1:0] align_addr(input logic [WORD_BITS-1:0] a,
                                                      input int unsigned ofs_bits);
    return a & ~((64'(1) << ofs_bits) - 64'(1));
  endfunction

endpackage

// File: rtl/muskbus_if.sv
// Muskbus port bundle; the Top modport is the master side seen by bus clients.
interface Muskbus;
  import MUSKBUS::*;

  logic                 bid;
  logic                 reqcyc;
  logic [TAG_BITS-1:0]  reqtag;
  logic [WORD_BITS-1:0] req;
  logic                 respack;
  logic                 respcyc;
  logic [WORD_BITS-1:0] resp;

  modport Top (
    output bid, reqcyc, reqtag, req, respack,
    input  respcyc, resp
  );

endinterface

// File: rtl/muskbus_req_fifo.sv
// Small synchronous request FIFO with registered storage and a combinational head.
module muskbus_req_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/muskbus_line_reader.sv
// Queued Muskbus line reader: one READ_MEM_TAG per request, BEATS response beats
// assembled into a line handed to the client under respcyc/respack.
module muskbus_line_reader
  import MUSKBUS::*;
#(
  parameter int unsigned LINE_BITS = 512,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  Muskbus.Top                  bus,
  input  logic                 reqcyc,
  output logic                 reqack,
  input  logic [63:0]          addr,
  output logic                 respcyc,
  input  logic                 respack,
  output logic [0:LINE_BITS-1] data,
  output logic [63:0]          resp_addr,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned BEATS    = LINE_BITS / 64;
  localparam int unsigned OFS_BITS = $clog2(LINE_BITS / 8);
  localparam int unsigned CW       = $clog2(BEATS + 1);
  localparam int unsigned IW       = $clog2(LINE_BITS);

  LINE_READER_STATE_T   state;
  logic [63:0]          cur_addr;
  logic [CW-1:0]        beat_cnt;
  logic [0:LINE_BITS-1] line_buf;
  logic [IW-1:0]        beat_ofs;

  logic [63:0] aligned;
  logic [63:0] head;
  logic        full;
  logic        empty;
  logic        pop;
  logic        accept;
  logic        bypass;

  // An idle reader with nothing queued starts the request directly, skipping the queue.
  assign aligned = align_addr(addr, OFS_BITS);
  assign pop     = !empty && ((state == IDLE) || ((state == DONE) && respack));
  assign reqack  = !full || pop;
  assign accept  = reqcyc && reqack;
  assign bypass  = (state == IDLE) && empty;

  muskbus_req_fifo #(
    .WIDTH (64),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && !bypass),
    .pop   (pop),
    .din   (aligned),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign beat_ofs = IW'(beat_cnt) << 6;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cur_addr <= '0;
      beat_cnt <= '0;
      line_buf <= '0;
      overrun  <= 1'b0;
    end else begin
      // Beats are always drained; any that land outside RECV are dropped and flagged.
      if (bus.respcyc && (state != RECV)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (!empty) begin
            cur_addr <= head;
            beat_cnt <= '0;
            state    <= REQ;
          end else if (accept) begin
            cur_addr <= aligned;
            beat_cnt <= '0;
            state    <= REQ;
          end
        end
        REQ: state <= RECV;
        RECV: begin
          if (bus.respcyc) begin
            line_buf[beat_ofs +: 64] <= bus.resp;
            beat_cnt                 <= beat_cnt + CW'(1);
            if (beat_cnt == CW'(BEATS - 1)) state <= DONE;
          end
        end
        DONE: begin
          if (respack) begin
            if (!empty) begin
              cur_addr <= head;
              beat_cnt <= '0;
              state    <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bid     = (state == REQ) || (state == RECV);
  assign bus.reqcyc  = (state == REQ);
  assign bus.reqtag  = (state == REQ) ? READ_MEM_TAG : '0;
  assign bus.req     = (state == REQ) ? cur_addr : '0;
  assign bus.respack = bus.respcyc;

  assign respcyc   = (state == DONE);
  assign data      = respcyc ? line_buf : '0;
  assign resp_addr = respcyc ? cur_addr : '0;
  assign busy      = (state != IDLE) || !empty;

endmodule
